// File: rtl/tdc_echo_serializer.sv
// tdc_echo_serializer
//   Emulates the serial result outputs of a GPX2-style TDC. There are CH
//   channels, and each channel reports ECHO echoes of W bits. For every echo
//   slot the block waits GAP_CYC idle cycles. It then shifts the echo MSB-first
//   on Sdo and raises Frame for the first FRAME_HI bits. After the last slot it
//   waits END_CYC idle cycles and pulses Done.
//   A one-deep holding buffer accepts a second measurement while one is being
//   shifted out. In skip mode, an echo slot that is zero on every channel is
//   left out completely.
// Ports
//   CpSl_Clk_i        serializer clock
//   CpSl_Rst_i        asynchronous reset, active-high
//   CpSl_Load_i       load strobe, accepted while CpSl_Ready_o=1
//   CpSv_EchoData_i   ch c at [c*ECHO*W +: ECHO*W], echo1 = top W bits
//   CpSl_SkipEmpty_i  skip all-zero echo slots (sampled with the load)
//   CpSl_Ready_o      holding buffer empty
//   CpSl_Busy_o       serializer not idle
//   CpSl_Done_o       one-cycle pulse when a measurement completes
//   CpSv_Frame_o      per-channel frame marker (registered)
//   CpSv_Sdo_o        per-channel serial data, MSB first (registered)
module tdc_echo_serializer #(
  parameter int CH       = 8,
  parameter int W        = 24,
  parameter int ECHO     = 3,
  parameter int FRAME_HI = 8,
  parameter int GAP_CYC  = 50,
  parameter int END_CYC  = 26,
  parameter int CNT_W    = 8
) (
  input  logic                 CpSl_Clk_i,
  input  logic                 CpSl_Rst_i,
  input  logic                 CpSl_Load_i,
  input  logic [CH*ECHO*W-1:0] CpSv_EchoData_i,
  input  logic                 CpSl_SkipEmpty_i,
  output logic                 CpSl_Ready_o,
  output logic                 CpSl_Busy_o,
  output logic                 CpSl_Done_o,
  output logic [CH-1:0]        CpSv_Frame_o,
  output logic [CH-1:0]        CpSv_Sdo_o
);

  localparam int DW     = CH*ECHO*W;
  localparam int SLOT_W = (ECHO > 1) ? $clog2(ECHO) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_SHIFT, ST_END} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DW-1:0]     act_q, act_d, buf_q, buf_d;
  logic              act_skip_q, act_skip_d, buf_skip_q, buf_skip_d;
  logic              buf_vld_q, buf_vld_d;
  logic              done_q, done_d;
  logic [CH-1:0]     frame_q, frame_d, sdo_q, sdo_d;

  logic              load_acc, launch, take_input, launch_skip;
  logic [DW-1:0]     launch_data;
  logic [SLOT_W:0]   sel;

  function automatic logic [W-1:0] echo_of(input logic [DW-1:0] d,
                                           input int unsigned c,
                                           input int unsigned s);
    return d[(c*ECHO + (ECHO-1-s))*W +: W];
  endfunction

  // Returns {found, index} of the first slot >= start that is sent, meaning it
  // is non-empty or skip mode is off.
  function automatic logic [SLOT_W:0] first_slot(input logic [DW-1:0] d,
                                                 input logic skip,
                                                 input int unsigned start);
    logic              found;
    logic              nz;
    logic [SLOT_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned s = 0; s < ECHO; s++) begin
      nz = 1'b0;
      for (int unsigned c = 0; c < CH; c++) nz = nz | (|echo_of(d, c, s));
      if (!found && s >= start && (!skip || nz)) begin
        found = 1'b1;
        idx   = SLOT_W'(s);
      end
    end
    return {found, idx};
  endfunction

  // The count value b is the bit index being sent. b >= W-FRAME_HI is the
  // same test as shift cycle n < FRAME_HI.
  function automatic logic [1:0] shift_bits(input logic [W-1:0] e,
                                            input logic [CNT_W-1:0] b);
    logic [W-1:0] sh;
    sh = e >> b;
    return {(|e) && (32'(b) >= 32'(W-FRAME_HI)), sh[0]};
  endfunction

  assign load_acc     = CpSl_Load_i && !buf_vld_q;
  assign CpSl_Ready_o = !buf_vld_q;
  assign CpSl_Busy_o  = (state_q != ST_IDLE);
  assign CpSl_Done_o  = done_q;
  assign CpSv_Frame_o = frame_q;
  assign CpSv_Sdo_o   = sdo_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    act_d       = act_q;
    act_skip_d  = act_skip_q;
    buf_d       = buf_q;
    buf_skip_d  = buf_skip_q;
    buf_vld_d   = buf_vld_q;
    done_d      = 1'b0;
    launch      = 1'b0;
    take_input  = 1'b0;
    launch_data = CpSv_EchoData_i;
    launch_skip = CpSl_SkipEmpty_i;
    sel         = '0;
    case (state_q)
      ST_IDLE: begin
        if (load_acc) begin
          launch     = 1'b1;
          take_input = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_SHIFT;
          cnt_d   = CNT_W'(W-1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          sel = first_slot(act_q, act_skip_q, 32'(slot_q) + 32'd1);
          if (sel[SLOT_W]) begin
            state_d = ST_GAP;
            slot_d  = sel[SLOT_W-1:0];
            cnt_d   = CNT_W'(GAP_CYC-1);
          end else begin
            state_d = ST_END;
            cnt_d   = CNT_W'(END_CYC-1);
          end
        end
      end
      ST_END: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          done_d = 1'b1;
          // Start the next measurement at once when one is waiting. A load
          // that arrives in this same cycle with the buffer empty goes straight
          // to the active register, so the buffer is never left full while
          // the FSM is idle.
          if (buf_vld_q) begin
            launch      = 1'b1;
            launch_data = buf_q;
            launch_skip = buf_skip_q;
            buf_vld_d   = 1'b0;
          end else if (load_acc) begin
            launch     = 1'b1;
            take_input = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_acc && !take_input) begin
      buf_d      = CpSv_EchoData_i;
      buf_skip_d = CpSl_SkipEmpty_i;
      buf_vld_d  = 1'b1;
    end

    if (launch) begin
      act_d      = launch_data;
      act_skip_d = launch_skip;
      sel        = first_slot(launch_data, launch_skip, 32'd0);
      if (sel[SLOT_W]) begin
        state_d = ST_GAP;
        slot_d  = sel[SLOT_W-1:0];
        cnt_d   = CNT_W'(GAP_CYC-1);
      end else begin
        state_d = ST_END;
        cnt_d   = CNT_W'(END_CYC-1);
      end
    end
  end

  always_comb begin
    sdo_d   = '0;
    frame_d = '0;
    if (state_q == ST_SHIFT) begin
      for (int unsigned c = 0; c < CH; c++) begin
        {frame_d[c], sdo_d[c]} = shift_bits(echo_of(act_q, c, 32'(slot_q)), cnt_q);
      end
    end
  end

  always_ff @(posedge CpSl_Clk_i or posedge CpSl_Rst_i) begin
    if (CpSl_Rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      slot_q     <= '0;
      act_q      <= '0;
      act_skip_q <= 1'b0;
      buf_q      <= '0;
      buf_skip_q <= 1'b0;
      buf_vld_q  <= 1'b0;
      done_q     <= 1'b0;
      frame_q    <= '0;
      sdo_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      act_q      <= act_d;
      act_skip_q <= act_skip_d;
      buf_q      <= buf_d;
      buf_skip_q <= buf_skip_d;
      buf_vld_q  <= buf_vld_d;
      done_q     <= done_d;
      frame_q    <= frame_d;
      sdo_q      <= sdo_d;
    end
  end

endmodule

// File: tb/tb_tdc_echo_serializer.sv
module tb_tdc_echo_serializer;

  localparam int CH   = 8;
  localparam int W    = 24;
  localparam int ECHO = 3;
  localparam int HMAX = 600;
  localparam int NV   = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 load;
  logic [CH*ECHO*W-1:0] data;
  logic                 skip;
  logic                 ready, busy, done;
  logic [CH-1:0]        frm, sdo;

  logic        load6;
  logic [31:0] data6;
  logic        skip6;
  logic        ready6, busy6, done6;
  logic [1:0]  frm6, sdo6;

  always #5 clk = ~clk;

  tdc_echo_serializer #(.CH(CH), .W(W), .ECHO(ECHO), .FRAME_HI(8), .GAP_CYC(50),
                        .END_CYC(26), .CNT_W(8)) dut (
    .CpSl_Clk_i(clk), .CpSl_Rst_i(rst), .CpSl_Load_i(load),
    .CpSv_EchoData_i(data), .CpSl_SkipEmpty_i(skip),
    .CpSl_Ready_o(ready), .CpSl_Busy_o(busy), .CpSl_Done_o(done),
    .CpSv_Frame_o(frm), .CpSv_Sdo_o(sdo));

  tdc_echo_serializer #(.CH(2), .W(16), .ECHO(1), .FRAME_HI(16), .GAP_CYC(1),
                        .END_CYC(3), .CNT_W(8)) dut6 (
    .CpSl_Clk_i(clk), .CpSl_Rst_i(rst), .CpSl_Load_i(load6),
    .CpSv_EchoData_i(data6), .CpSl_SkipEmpty_i(skip6),
    .CpSl_Ready_o(ready6), .CpSl_Busy_o(busy6), .CpSl_Done_o(done6),
    .CpSv_Frame_o(frm6), .CpSv_Sdo_o(sdo6));

  typedef struct {
    logic [W-1:0] ech [CH][ECHO];
    logic         skip;
    int           starts [ECHO];
    int           done;
  } vec_t;

  typedef struct {
    int           start;
    int           ch;
    logic [W-1:0] word;
    logic [W-1:0] frm;
  } exp_t;

  vec_t tv [NV];
  exp_t sbq [$];

  logic [CH-1:0] h_sdo [HMAX];
  logic [CH-1:0] h_frm [HMAX];
  logic          h_done [HMAX];
  logic          h_busy [HMAX];
  logic          h_rdy [HMAX];
  int            nh;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t blank(input logic s, input int s0, input int s1, input int s2,
                                 input int d);
    vec_t v;
    for (int c = 0; c < CH; c++)
      for (int e = 0; e < ECHO; e++) v.ech[c][e] = '0;
    v.skip = s;
    v.starts[0] = s0;
    v.starts[1] = s1;
    v.starts[2] = s2;
    v.done = d;
    return v;
  endfunction

  function automatic logic [CH*ECHO*W-1:0] pack(input vec_t v);
    logic [CH*ECHO*W-1:0] d;
    for (int c = 0; c < CH; c++)
      d[c*ECHO*W +: ECHO*W] = {v.ech[c][0], v.ech[c][1], v.ech[c][2]};
    return d;
  endfunction

  task automatic drive_load(input logic [CH*ECHO*W-1:0] d, input logic s);
    @(negedge clk);
    data = d;
    skip = s;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic push_txn(input vec_t v, input int base);
    exp_t e;
    for (int s = 0; s < ECHO; s++) begin
      if (v.starts[s] >= 0) begin
        for (int c = 0; c < CH; c++) begin
          e.start = base + v.starts[s];
          e.ch    = c;
          e.word  = v.ech[c][s];
          e.frm   = (v.ech[c][s] != '0) ? 24'hFF0000 : 24'h000000;
          sbq.push_back(e);
        end
      end
    end
  endtask

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      h_sdo[k]  = sdo;
      h_frm[k]  = frm;
      h_done[k] = done;
      h_busy[k] = busy;
      h_rdy[k]  = ready;
    end
    nh = n;
  endtask

  task automatic drain(input string tag);
    exp_t         e;
    logic [W-1:0] gw, gf;
    int           es = 0, ef = 0, as = 0, af = 0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      for (int n = 0; n < W; n++) begin
        gw[W-1-n] = (e.start + n < nh) ? h_sdo[e.start+n][e.ch] : 1'bx;
        gf[W-1-n] = (e.start + n < nh) ? h_frm[e.start+n][e.ch] : 1'bx;
      end
      chk($sformatf("%s_sdo_c%0d_t%0d", tag, e.ch, e.start), 64'(gw), 64'(e.word));
      chk($sformatf("%s_frm_c%0d_t%0d", tag, e.ch, e.start), 64'(gf), 64'(e.frm));
      es += $countones(e.word);
      ef += $countones(e.frm);
    end
    for (int k = 0; k < nh; k++) begin
      as += $countones(h_sdo[k]);
      af += $countones(h_frm[k]);
    end
    chk({tag, "_sdo_total"}, 64'(as), 64'(es));
    chk({tag, "_frm_total"}, 64'(af), 64'(ef));
  endtask

  task automatic done_stats(output int cnt, output int p0, output int p1, output int nbusy,
                            output int nrdy);
    cnt = 0; p0 = -1; p1 = -1; nbusy = 0; nrdy = 0;
    for (int k = 0; k < nh; k++) begin
      if (h_done[k]) begin
        if (cnt == 0) p0 = k;
        else if (cnt == 1) p1 = k;
        cnt++;
      end
      if (h_busy[k]) nbusy++;
      if (h_rdy[k]) nrdy++;
    end
  endtask

  task automatic run_vec(input int i);
    int cnt, p0, p1, nb, nr;
    drive_load(pack(tv[i]), tv[i].skip);
    push_txn(tv[i], 0);
    capture(300);
    drain($sformatf("v%0d", i));
    done_stats(cnt, p0, p1, nb, nr);
    chk($sformatf("v%0d_done_cnt", i), 64'(cnt), 64'd1);
    chk($sformatf("v%0d_done_pos", i), 64'(p0), 64'(tv[i].done));
    chk($sformatf("v%0d_busy_cyc", i), 64'(nb), 64'(tv[i].done));
    chk($sformatf("v%0d_ready_cyc", i), 64'(nr), 64'd300);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cnt, p0, p1, nb, nr;
    logic [15:0] w6, f6;
    int f6tot, c1tot, d6pos, d6cnt;

    tv[0] = blank(1'b0, 51, 125, 199, 248);
    tv[0].ech[0][0] = 24'hABCDEF; tv[0].ech[0][1] = 24'h123456; tv[0].ech[0][2] = 24'h000001;
    tv[1] = blank(1'b1, 51, -1, 125, 174);
    tv[1].ech[0][0] = 24'hABCDEF; tv[1].ech[0][2] = 24'h000001; tv[1].ech[3][2] = 24'h800000;
    tv[2] = blank(1'b1, -1, -1, -1, 26);
    tv[3] = blank(1'b0, 51, 125, 199, 248);
    tv[3].ech[1][1] = 24'hFFFFFF; tv[3].ech[7][0] = 24'h800000; tv[3].ech[7][2] = 24'h000007;
    tv[4] = blank(1'b1, -1, 51, 125, 174);
    tv[4].ech[2][1] = 24'h5A5A5A; tv[4].ech[5][2] = 24'hC00003;
    tv[5] = blank(1'b1, -1, -1, 51, 100);
    tv[5].ech[6][2] = 24'hFFFFFF;
    tv[6] = blank(1'b0, 51, 125, 199, 248);

    rst = 1'b1; load = 1'b0; data = '0; skip = 1'b0;
    load6 = 1'b0; data6 = '0; skip6 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_frame", 64'(frm), 64'd0);
    chk("rst_sdo", 64'(sdo), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Load A, then B into the buffer, then C while the buffer is full.
    drive_load(pack(tv[0]), tv[0].skip);
    @(negedge clk);
    data = pack(tv[3]); skip = tv[3].skip; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    chk("t4_ready_full", 64'(ready), 64'd0);
    chk("t4_busy", 64'(busy), 64'd1);
    data = pack(tv[1]); skip = tv[1].skip; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    capture(560);
    push_txn(tv[0], -2);
    push_txn(tv[3], 246);
    drain("t4");
    done_stats(cnt, p0, p1, nb, nr);
    chk("t4_done_cnt", 64'(cnt), 64'd2);
    chk("t4_done_a", 64'(p0), 64'd246);
    chk("t4_done_b", 64'(p1), 64'd494);
    chk("t4_busy_cyc", 64'(nb), 64'd494);
    chk("t4_ready_before", 64'(h_rdy[245]), 64'd0);
    chk("t4_ready_after", 64'(h_rdy[246]), 64'd1);

    // Reset in the middle of echo2.
    drive_load(pack(tv[0]), tv[0].skip);
    repeat (131) @(negedge clk);
    chk("t5_pre_frame", 64'(frm[0]), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_frame", 64'(frm), 64'd0);
    chk("t5_rst_sdo", 64'(sdo), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_ready", 64'(ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    capture(300);
    drain("t5_quiet");
    done_stats(cnt, p0, p1, nb, nr);
    chk("t5_no_done", 64'(cnt), 64'd0);
    run_vec(3);

    // Small instance: W=16, ECHO=1, GAP_CYC=1, FRAME_HI=W.
    @(negedge clk);
    data6 = {16'h0000, 16'hA5C3};
    load6 = 1'b1;
    @(posedge clk);
    #1 load6 = 1'b0;
    f6tot = 0; c1tot = 0; d6pos = -1; d6cnt = 0; w6 = '0; f6 = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 1) chk("t6_bit_before_start", 64'(frm6[0]), 64'd0);
      if (k >= 2 && k < 18) begin
        w6[17-k] = sdo6[0];
        f6[17-k] = frm6[0];
      end
      f6tot += int'(frm6[0]);
      c1tot += int'(frm6[1]) + int'(sdo6[1]);
      if (done6) begin
        if (d6cnt == 0) d6pos = k;
        d6cnt++;
      end
    end
    chk("t6_sdo_word", 64'(w6), 64'h0000_0000_0000_A5C3);
    chk("t6_frame_word", 64'(f6), 64'h0000_0000_0000_FFFF);
    chk("t6_frame_total", 64'(f6tot), 64'd16);
    chk("t6_ch1_idle", 64'(c1tot), 64'd0);
    chk("t6_done_pos", 64'(d6pos), 64'd20);
    chk("t6_done_cnt", 64'(d6cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
